// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, fetches opcode plus 0-2 operand bytes,
// and hands the complete instruction to execute over a valid/ack handshake.
module fetch_sequencer #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        run_mode,
  input  logic        step_req,
  input  logic [7:0]  rom_data,
  input  logic        exec_ack,
  input  logic        pc_load,
  input  logic [15:0] pc_load_val,
  output logic [15:0] addr_bus,
  output logic        mem_rd,
  output logic        instr_valid,
  output logic [7:0]  opcode,
  output logic [15:0] operand,
  output logic [1:0]  instr_len,
  output logic [15:0] instr_pc,
  output logic        busy
);

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_OP,
    FETCH_LO,
    FETCH_HI,
    ISSUE
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        pc_q, pc_d;
  logic [7:0]         opcode_q, opcode_d;
  logic [15:0]        operand_q, operand_d;
  logic [15:0]        instr_pc_q, instr_pc_d;
  logic [1:0]         len_q, len_d;
  logic [SYNC_N-1:0]  sync_q;
  logic               step_prev_q;
  logic               step_pulse;
  logic [1:0]         rom_len;

  function automatic logic [1:0] decode_len(input logic [7:0] o);
    if (o == 8'h00 || o == 8'h40 || o == 8'h60 || o[3:0] == 4'h8 || o[3:0] == 4'hA)
      return 2'd1;
    if (o == 8'h20 || o[3:2] == 2'b11 || ((o[3:0] == 4'h9 || o[3:0] == 4'hB) && o[4]))
      return 2'd3;
    return 2'd2;
  endfunction

  assign rom_len    = decode_len(rom_data);
  assign step_pulse = sync_q[SYNC_N-1] & ~step_prev_q;

  // The edge detector runs in every state, so presses outside IDLE are simply lost.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync_q      <= '0;
      step_prev_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_N-2:0], step_req};
      step_prev_q <= sync_q[SYNC_N-1];
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_VECTOR;
      opcode_q   <= 8'h00;
      operand_q  <= 16'h0000;
      instr_pc_q <= 16'h0000;
      len_q      <= 2'd1;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      opcode_q   <= opcode_d;
      operand_q  <= operand_d;
      instr_pc_q <= instr_pc_d;
      len_q      <= len_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    opcode_d   = opcode_q;
    operand_d  = operand_q;
    instr_pc_d = instr_pc_q;
    len_d      = len_q;
    case (state_q)
      IDLE: begin
        if (run_mode || step_pulse) state_d = FETCH_OP;
      end
      FETCH_OP: begin
        opcode_d   = rom_data;
        instr_pc_d = pc_q;
        operand_d  = 16'h0000;
        len_d      = rom_len;
        pc_d       = pc_q + 16'd1;
        state_d    = (rom_len == 2'd1) ? ISSUE : FETCH_LO;
      end
      FETCH_LO: begin
        operand_d[7:0] = rom_data;
        pc_d           = pc_q + 16'd1;
        state_d        = (len_q == 2'd3) ? FETCH_HI : ISSUE;
      end
      FETCH_HI: begin
        operand_d[15:8] = rom_data;
        pc_d            = pc_q + 16'd1;
        state_d         = ISSUE;
      end
      ISSUE: begin
        // PC already points past the instruction unless execute redirects it.
        if (exec_ack) begin
          state_d = IDLE;
          if (pc_load) pc_d = pc_load_val;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign addr_bus    = pc_q;
  assign mem_rd      = (state_q == FETCH_OP) || (state_q == FETCH_LO) || (state_q == FETCH_HI);
  assign instr_valid = (state_q == ISSUE);
  assign busy        = (state_q != IDLE);
  assign opcode      = opcode_q;
  assign operand     = operand_q;
  assign instr_len   = len_q;
  assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, single-step and reset sequences,
// then random instructions checked against a transaction-level ROM/PC model.
module tb_fetch_sequencer;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic        run_mode = 1'b1;
  logic        step_req = 1'b0;
  logic [7:0]  rom_data;
  logic        exec_ack = 1'b0;
  logic        pc_load = 1'b0;
  logic [15:0] pc_load_val = 16'h0000;
  logic [15:0] addr_bus;
  logic        mem_rd;
  logic        instr_valid;
  logic [7:0]  opcode;
  logic [15:0] operand;
  logic [1:0]  instr_len;
  logic [15:0] instr_pc;
  logic        busy;

  logic [7:0] rom [0:65535];
  assign rom_data = rom[addr_bus];

  int checks = 0;
  int passed = 0;

  fetch_sequencer dut (
    .clk_in(clk_in), .reset(reset), .run_mode(run_mode), .step_req(step_req),
    .rom_data(rom_data), .exec_ack(exec_ack), .pc_load(pc_load), .pc_load_val(pc_load_val),
    .addr_bus(addr_bus), .mem_rd(mem_rd), .instr_valid(instr_valid), .opcode(opcode),
    .operand(operand), .instr_len(instr_len), .instr_pc(instr_pc), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int ref_len(input logic [7:0] o);
    if (o == 8'h00 || o == 8'h40 || o == 8'h60 || o[3:0] == 4'h8 || o[3:0] == 4'hA) return 1;
    if (o == 8'h20 || o[3:2] == 2'b11 || ((o[3:0] == 4'h9 || o[3:0] == 4'hB) && o[4])) return 3;
    return 2;
  endfunction

  // Called at a negedge with the DUT in IDLE and run_mode = 1.
  task automatic do_instr(input logic [15:0] pc0, input logic [7:0] op, input logic [15:0] opr,
                          input int len, input int hold, input logic ld, input logic [15:0] ldv);
    int          cyc;
    logic        seq_ok;
    logic        hold_ok;
    logic [15:0] nxt;
    cyc = 0;
    seq_ok = 1'b1;
    while (!instr_valid && cyc < 20) begin
      @(negedge clk_in);
      cyc++;
      if (!instr_valid && (!mem_rd || !busy || addr_bus != pc0 + 16'(cyc - 1))) seq_ok = 1'b0;
    end
    chk("latency", 32'(cyc), 32'(len + 1));
    chk("fetch_seq", {31'd0, seq_ok}, 32'd1);
    chk("opcode", {24'd0, opcode}, {24'd0, op});
    chk("operand", {16'd0, operand}, {16'd0, opr});
    chk("instr_len", {30'd0, instr_len}, 32'(len));
    chk("instr_pc", {16'd0, instr_pc}, {16'd0, pc0});
    nxt = pc0 + 16'(len);
    for (int h = 0; h < hold; h++) begin
      pc_load = 1'b1;
      pc_load_val = 16'($urandom);
      @(negedge clk_in);
      hold_ok = instr_valid && busy && !mem_rd && opcode == op && operand == opr &&
                32'(instr_len) == 32'(len) && instr_pc == pc0 && addr_bus == nxt;
      chk("hold_stable", {31'd0, hold_ok}, 32'd1);
    end
    exec_ack = 1'b1;
    pc_load = ld;
    pc_load_val = ldv;
    @(negedge clk_in);
    exec_ack = 1'b0;
    pc_load = 1'b0;
    chk("next_pc", {16'd0, addr_bus}, {16'd0, ld ? ldv : nxt});
    chk("idle_after_ack", {31'd0, busy}, 32'd0);
    $display("instr pc=%h op=%h operand=%h len=%0d hold=%0d load=%0d next=%h",
             pc0, op, opr, len, hold, ld, addr_bus);
  endtask

  typedef struct {
    logic [15:0] pc;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    int          len;
    logic [15:0] opr;
    int          hold;
    logic        ld;
    logic [15:0] ldv;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [15:0] mpc;
    logic [7:0]  rb0, rb1, rb2;
    logic [15:0] ropr;
    logic [15:0] rldv;
    logic        found;
    int          rlen;
    int          nvalid;
    int          nbusy;

    vecs[0]  = '{16'h0000, 8'hA0, 8'hFF, 8'h00, 2, 16'h00FF, 0,  1'b0, 16'h0000};
    vecs[1]  = '{16'h0002, 8'h4C, 8'h34, 8'h12, 3, 16'h1234, 2,  1'b1, 16'h1234};
    vecs[2]  = '{16'h1234, 8'hEA, 8'h00, 8'h00, 1, 16'h0000, 10, 1'b1, 16'hFFFE};
    vecs[3]  = '{16'hFFFE, 8'hAD, 8'h00, 8'h80, 3, 16'h8000, 0,  1'b0, 16'h0000};
    vecs[4]  = '{16'h0001, 8'h00, 8'h00, 8'h00, 1, 16'h0000, 1,  1'b1, 16'h0200};
    vecs[5]  = '{16'h0200, 8'h20, 8'hCD, 8'hAB, 3, 16'hABCD, 0,  1'b1, 16'h0300};
    vecs[6]  = '{16'h0300, 8'h19, 8'h11, 8'h22, 3, 16'h2211, 1,  1'b1, 16'h0400};
    vecs[7]  = '{16'h0400, 8'h09, 8'h55, 8'h00, 2, 16'h0055, 0,  1'b1, 16'h0500};
    vecs[8]  = '{16'h0500, 8'h60, 8'h00, 8'h00, 1, 16'h0000, 3,  1'b1, 16'h0600};
    vecs[9]  = '{16'h0600, 8'h8D, 8'h78, 8'h56, 3, 16'h5678, 0,  1'b1, 16'h0700};
    vecs[10] = '{16'h0700, 8'h0B, 8'h33, 8'h00, 2, 16'h0033, 2,  1'b1, 16'h0800};
    vecs[11] = '{16'h0800, 8'h1B, 8'h44, 8'h66, 3, 16'h6644, 0,  1'b0, 16'h0000};

    for (int a = 0; a < 65536; a++) rom[a] = 8'hEA;

    // Reset state
    repeat (3) @(negedge clk_in);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_pc", {16'd0, addr_bus}, 32'h0000);
    chk("rst_fields", {opcode, operand, 6'd0, instr_len}, 32'h0000_0001);
    chk("rst_instr_pc", {16'd0, instr_pc}, 32'h0000);

    // Directed vector table in free-run mode
    for (int i = 0; i < 12; i++) begin
      rom[vecs[i].pc] = vecs[i].b0;
      if (vecs[i].len > 1) rom[16'(vecs[i].pc + 16'd1)] = vecs[i].b1;
      if (vecs[i].len > 2) rom[16'(vecs[i].pc + 16'd2)] = vecs[i].b2;
      if (i == 0) reset = 1'b0;
      do_instr(vecs[i].pc, vecs[i].b0, vecs[i].opr, vecs[i].len, vecs[i].hold,
               vecs[i].ld, vecs[i].ldv);
    end
    mpc = 16'h0803;

    // Random instructions against the ROM/PC model
    for (int n = 0; n < 40; n++) begin
      rb0 = 8'($urandom);
      rb1 = 8'($urandom);
      rb2 = 8'($urandom);
      rom[mpc] = rb0;
      rom[16'(mpc + 16'd1)] = rb1;
      rom[16'(mpc + 16'd2)] = rb2;
      rlen = ref_len(rb0);
      ropr = (rlen == 1) ? 16'h0000 : (rlen == 2) ? {8'h00, rb1} : {rb2, rb1};
      rldv = ($urandom_range(0, 2) == 0) ? 16'(16'hFFFC + 16'($urandom_range(0, 3))) : 16'($urandom);
      found = ($urandom_range(0, 3) == 0);
      do_instr(mpc, rb0, ropr, rlen, $urandom_range(0, 3), found, rldv);
      mpc = found ? rldv : 16'(mpc + 16'(rlen));
    end

    // Single-step: idle without presses, one press = one instruction, press mid-fetch ignored
    run_mode = 1'b0;
    exec_ack = 1'b1;
    rom[mpc] = 8'h8D;
    rom[16'(mpc + 16'd1)] = 8'h11;
    rom[16'(mpc + 16'd2)] = 8'h22;
    nbusy = 0;
    repeat (100) begin
      @(negedge clk_in);
      if (busy) nbusy++;
    end
    chk("step_idle_busy", 32'(nbusy), 32'd0);
    step_req = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk_in);
      if (mem_rd) found = 1'b1;
    end
    chk("step_fetch_op", {15'd0, found, addr_bus}, {15'd0, 1'b1, mpc});
    step_req = 1'b0;
    @(negedge clk_in);
    chk("step_fetch_lo", {15'd0, mem_rd, addr_bus}, {15'd0, 1'b1, 16'(mpc + 16'd1)});
    step_req = 1'b1;
    nvalid = 0;
    ropr = 16'h0000;
    repeat (40) begin
      @(negedge clk_in);
      if (instr_valid) begin
        nvalid++;
        ropr = operand;
      end
    end
    chk("step_one_instr", 32'(nvalid), 32'd1);
    chk("step_operand", {16'd0, ropr}, 32'h2211);
    chk("step_back_idle", {15'd0, busy, addr_bus}, {15'd0, 1'b0, 16'(mpc + 16'd3)});
    $display("step pc=%h issued=%0d operand=%h", mpc, nvalid, ropr);
    step_req = 1'b0;
    nbusy = 0;
    repeat (10) begin
      @(negedge clk_in);
      if (busy) nbusy++;
    end
    chk("step_release_ignored", 32'(nbusy), 32'd0);
    mpc = 16'(mpc + 16'd3);
    exec_ack = 1'b0;
    run_mode = 1'b1;

    // Reset asserted during FETCH_HI
    rom[mpc] = 8'hAD;
    rom[16'(mpc + 16'd1)] = 8'h34;
    rom[16'(mpc + 16'd2)] = 8'h12;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk_in);
      if (mem_rd && addr_bus == 16'(mpc + 16'd2)) found = 1'b1;
    end
    chk("reach_fetch_hi", {31'd0, found}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_ctl", {29'd0, busy, mem_rd, instr_valid}, 32'd0);
    chk("async_rst_pc", {16'd0, addr_bus}, 32'h0000);
    chk("async_rst_fields", {opcode, operand, 6'd0, instr_len}, 32'h0000_0001);
    $display("reset mid-fetch pc=%h busy=%0d", addr_bus, busy);
    @(negedge clk_in);
    rom[16'h0000] = 8'hA9;
    rom[16'h0001] = 8'h5A;
    reset = 1'b0;
    do_instr(16'h0000, 8'hA9, 16'h005A, 2, 1, 1'b0, 16'h0000);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
